data_mem_bus: RTL

Data-side responder for the core's RAM port (ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o, ram_data_i). It has three parts:
- a word-organised data RAM with byte-lane writes;
- a small memory-mapped timer (64-bit mtime/mtimecmp with interrupt output);
- a tohost halt register for simulation termination.

Reads are combinational so the MEM stage sees data in the same cycle. Writes commit at the rising clock edge.

---
 rtl/data_mem_bus_if.sv | 13 +
 rtl/data_mem_bus.sv | 107 ++++++++++
 2 files changed

// File: rtl/data_mem_bus_if.sv
// Core data-port bus: access strobes, byte address, lane enables and data in both directions.
// The master drives the request fields; the slave returns combinational read data.
interface data_mem_bus_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output ce_i, we_i, addr_i, sel_i, data_i, input data_o);
    modport slave  (input ce_i, we_i, addr_i, sel_i, data_i, output data_o);
endinterface

// File: rtl/data_mem_bus.sv
// Data-side responder for the core RAM port: byte-lane RAM, 64-bit machine timer,
// and a tohost halt register, all behind one combinational-read bus.
module data_mem_bus #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_bus_if.slave   bus,
    output logic            timer_irq_o,
    output logic            halt_o,
    output logic [31:0]     tohost_o,
    output logic            bus_err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [63:0]   mtime, mtime_next, mtimecmp;
    logic [31:0]   tohost, tohost_next, scratch;
    logic [31:0]   mmio_off, rdata;
    logic [AW-1:0] widx;
    logic [3:0]    reg_sel;
    logic          in_ram, in_mmio, wr, rd, mmio_wr;

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++)
            m[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return m;
    endfunction

    assign in_ram   = (bus.addr_i[31:AW+2] == '0);
    assign mmio_off = bus.addr_i - MMIO_BASE;
    assign in_mmio  = (bus.addr_i >= MMIO_BASE) && (mmio_off < 32'd64);
    assign widx     = bus.addr_i[AW+1:2];
    assign reg_sel  = bus.addr_i[5:2];
    assign wr       = bus.ce_i && bus.we_i;
    assign rd       = bus.ce_i && !bus.we_i;
    // An empty lane mask must not even pause the timer, so it gates all MMIO writes.
    assign mmio_wr  = wr && in_mmio && (bus.sel_i != 4'b0000);

    always_ff @(posedge clk) begin
        if (wr && in_ram) begin
            for (int i = 0; i < 4; i++)
                if (bus.sel_i[i]) mem[widx][8*i +: 8] <= bus.data_i[8*i +: 8];
        end
    end

    always_comb begin
        mtime_next  = mtime + 64'd1;
        tohost_next = merge(tohost, bus.data_i, bus.sel_i);
        if (mmio_wr && reg_sel == 4'd0)
            mtime_next = {mtime[63:32], merge(mtime[31:0], bus.data_i, bus.sel_i)};
        else if (mmio_wr && reg_sel == 4'd1)
            mtime_next = {merge(mtime[63:32], bus.data_i, bus.sel_i), mtime[31:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime       <= '0;
            mtimecmp    <= '1;
            tohost      <= '0;
            scratch     <= '0;
            timer_irq_o <= 1'b0;
            halt_o      <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            mtime       <= mtime_next;
            timer_irq_o <= (mtime >= mtimecmp);
            if (bus.ce_i && !in_ram && !in_mmio) bus_err_o <= 1'b1;
            if (mmio_wr) begin
                case (reg_sel)
                    4'd2: mtimecmp[31:0]  <= merge(mtimecmp[31:0], bus.data_i, bus.sel_i);
                    4'd3: mtimecmp[63:32] <= merge(mtimecmp[63:32], bus.data_i, bus.sel_i);
                    4'd4: begin
                        tohost <= tohost_next;
                        if (tohost_next != 32'd0) halt_o <= 1'b1;
                    end
                    4'd5: scratch <= merge(scratch, bus.data_i, bus.sel_i);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (in_ram) begin
            rdata = mem[widx];
        end else if (in_mmio) begin
            case (reg_sel)
                4'd0:    rdata = mtime[31:0];
                4'd1:    rdata = mtime[63:32];
                4'd2:    rdata = mtimecmp[31:0];
                4'd3:    rdata = mtimecmp[63:32];
                4'd4:    rdata = tohost;
                4'd5:    rdata = scratch;
                default: rdata = 32'd0;
            endcase
        end
    end

    assign bus.data_o = rd ? rdata : 32'd0;
    assign tohost_o   = tohost;
endmodule
